// File: rtl/ramf_fifo_ctrl_if.sv
// ramf_fifo_ctrl_if: handshake and RAMF wiring bundle for ramf_fifo_ctrl.
// slave  : the FIFO controller.
// master : the surroundings (producer, consumer and the attached RAMF).
interface ramf_fifo_ctrl_if #(
    parameter int RAMD_W = 12,
    parameter int RAMA_W = 6
);
    // Producer / consumer side
    logic              flush;
    logic              wr_en;
    logic [RAMD_W-1:0] wr_data;
    logic              rd_req;
    logic [RAMD_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic [RAMA_W:0]   count;
    logic              overflow;
    logic              underflow;
    logic              almost_full;

    // RAMF side
    logic [RAMD_W-1:0] ram_d;
    logic [RAMA_W-1:0] ram_waddr;
    logic [RAMA_W-1:0] ram_raddr;
    logic              ram_we;
    logic [RAMD_W-1:0] ram_q;

    modport slave (
        input  flush, wr_en, wr_data, rd_req, ram_q,
        output rd_data, rd_valid, full, empty, count, overflow, underflow,
               almost_full, ram_d, ram_waddr, ram_raddr, ram_we
    );

    modport master (
        output flush, wr_en, wr_data, rd_req, ram_q,
        input  rd_data, rd_valid, full, empty, count, overflow, underflow,
               almost_full, ram_d, ram_waddr, ram_raddr, ram_we
    );
endinterface

// File: rtl/ramf_fifo_ctrl.sv
// ramf_fifo_ctrl: turns one RAMF (simple dual-port RAM, registered read
// address, combinational q) into a synchronous FIFO of depth 2**RAMA_W.
// Owns the pointers and occupancy count, gates accesses against full/empty
// and marks the RAM's one-cycle read latency with rd_valid.
// Optional build macro: FIFO_ALMOST_EN enables the registered almost_full
// flag (count >= DEPTH - AF_MARGIN); otherwise almost_full is tied low.
module ramf_fifo_ctrl #(
    parameter int RAMD_W    = 12,
    parameter int RAMA_W    = 6,
    parameter int AF_MARGIN = 2
) (
    input  logic             clk,
    input  logic             rst,
    ramf_fifo_ctrl_if.slave  fifo
);
    localparam int              CNT_W    = RAMA_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(2 ** RAMA_W);

    generate
        if (AF_MARGIN < 1 || AF_MARGIN > (2 ** RAMA_W) - 1) begin : g_bad_margin
            $error("ramf_fifo_ctrl: AF_MARGIN must lie in 1..DEPTH-1");
        end
    endgenerate

    logic [RAMA_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [RAMA_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              rd_valid_q, rd_valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              full, empty, wr_acc, rd_acc;

    // Accepts are judged on the pre-edge occupancy, so a full FIFO can still
    // take a read and an empty one a write in the same cycle.
    assign full   = (count_q == FULL_CNT);
    assign empty  = (count_q == '0);
    assign wr_acc = fifo.wr_en & ~full;
    assign rd_acc = fifo.rd_req & ~empty;

    // RAMF drive; flush suppresses the write strobe but leaves contents alone.
    assign fifo.ram_we    = wr_acc & ~fifo.flush;
    assign fifo.ram_waddr = wr_ptr_q;
    assign fifo.ram_d     = fifo.wr_data;
    assign fifo.ram_raddr = rd_ptr_q;

    // The RAMF registers raddr, so q already holds the popped word one cycle
    // after the accept; pass it straight through.
    assign fifo.rd_data   = fifo.ram_q;
    assign fifo.rd_valid  = rd_valid_q;
    assign fifo.full      = full;
    assign fifo.empty     = empty;
    assign fifo.count     = count_q;
    assign fifo.overflow  = overflow_q;
    assign fifo.underflow = underflow_q;

    // Next-state for pointers, count, valid strobe and sticky error flags.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rd_valid_d  = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (fifo.flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            rd_valid_d  = rd_acc;
            overflow_d  = overflow_q  | (fifo.wr_en  & full);
            underflow_d = underflow_q | (fifo.rd_req & empty);
        end
    end

    // State registers; asynchronous reset drops any pending rd_valid at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

`ifdef FIFO_ALMOST_EN
    localparam logic [CNT_W-1:0] AF_LEVEL = FULL_CNT - CNT_W'(AF_MARGIN);

    logic almost_full_q, almost_full_d;

    // Threshold is taken on the next count so the flag moves with count.
    always_comb begin
        almost_full_d = fifo.flush ? 1'b0 : (count_d >= AF_LEVEL);
    end

    // almost_full register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) almost_full_q <= 1'b0;
        else     almost_full_q <= almost_full_d;
    end

    assign fifo.almost_full = almost_full_q;
`else
    assign fifo.almost_full = 1'b0;
`endif

endmodule
